vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480@60 VGA raster timing from the system clock.
- Feeds the raw scan coordinates to the coordinate/zoom mapper as its x_in/y_in.
- Delays the sync and blank signals by a parameterised number of pixel ticks so they stay aligned with the mapper-plus-memory read latency at the DAC.
- Sits directly upstream of the mapper; also drives the VGA connector sync pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel tick (50 MHz -> 25 MHz); legal 1..16
- PIPE_DELAY, 2, pixel ticks of delay on hsync_n/vsync_n/blank_n; legal 0..8

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- pix_tick  out  1  pixel-rate enable, high one clock in every CLK_DIV
- x_out  out  10  current horizontal count, 0..799 (to mapper x_in)
- y_out  out  10  current vertical count, 0..524 (to mapper y_in)
- active  out  1  undelayed: x_out<H_ACTIVE and y_out<V_ACTIVE
- hsync_n  out  1  delayed horizontal sync, active low
- vsync_n  out  1  delayed vertical sync, active low
- blank_n  out  1  delayed active-video flag, low = blank
- line_start  out  1  one-clock pulse: pix_tick and x_out==0
- frame_start  out  1  one-clock pulse: pix_tick and x_out==0 and y_out==0

Behaviour:
- Derived constants: H_TOTAL = sum of the four H values = 800; V_TOTAL = sum of the four V values = 525.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - pix_tick = (div_cnt==CLK_DIV-1), decoded from the register. CLK_DIV=1 gives pix_tick constantly high.
- Horizontal counter (h_cnt): on pix_tick, increments; at H_TOTAL-1 it wraps to 0.
- Vertical counter (v_cnt): advances only on a tick where h_cnt wraps; at V_TOTAL-1 it wraps to 0.
- x_out/y_out are h_cnt/v_cnt directly.
  - Values above 639/479 are driven unchanged.
  - The mapper handles out-of-window coordinates via its fallback address.
- Sync decode, raw (undelayed):
  - hs_raw low when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw low when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - blank_raw = active.
- Delay line:
  - {hs_raw, vs_raw, blank_raw} enter a PIPE_DELAY-deep shift register that advances only on pix_tick.
  - The stage outputs drive hsync_n/vsync_n/blank_n.
  - PIPE_DELAY=0: the outputs are the raw decodes, combinational from the counters.
- line_start/frame_start are combinational from the registered state plus pix_tick, and are undelayed.
- Reset (synchronous, dominates every other event in the same cycle):
  - div_cnt=0, h_cnt=0, v_cnt=0.
  - All delay stages load hsync_n=1, vsync_n=1, blank_n=0.
  - Hence x_out=0, y_out=0, active=1 (coordinate 0,0 is active), pix_tick=0 unless CLK_DIV=1, hsync_n=1, vsync_n=1, blank_n=0.
- First tick after reset release occurs CLK_DIV-1 clocks later. It has h=v=0, so frame_start and line_start pulse on that tick.
- Reset asserted mid-frame: counters and delay line clear on that edge; no partial sync pulse persists beyond it.
- Width rule: counters are 10 bits; H_TOTAL and V_TOTAL must be <= 1024. Parameter violations are flagged by an elaboration-time check.

Decomposition:
- Shared package vga_pkg holds:
  - the default 640x480 timing localparams (H_/V_ values, H_TOTAL, V_TOTAL);
  - the screen window constants used by the mapper: 320x240 image, offsets 160/120, fallback address;
  - a struct/typedef grouping {hsync_n, vsync_n, blank_n}.
- One sub-module is natural: sync_delay_line.
  - Parameterised width and depth; shift register with a shared enable.
  - Reused later for delaying other pixel-aligned signals.

Test Plan:
- Reset, then release with CLK_DIV=2 -> pix_tick first high 1 clock after release; x_out=0, y_out=0; frame_start=1 and line_start=1 in that same clock; hsync_n=1, vsync_n=1, blank_n=0 before the delay line fills.
- Run one full line -> pix_tick period exactly 2 clocks; x_out steps 0..799 then wraps to 0 while y_out increments to 1; the raw hsync low window covers x 656..751 (96 ticks); hsync_n follows it 2 ticks later (x 658..753).
- Run one full frame -> vsync_n low for exactly 2 lines (raw y 490..491); frame_start pulses once per 420000 ticks (800x525); blank_n high for exactly 640x480=307200 ticks per frame.
- Assert reset for one clock at x=700, y=300 -> next clock x_out=0, y_out=0, hsync_n=1, blank_n=0; the sequence restarts exactly as after power-up reset.
- Elaborate with CLK_DIV=1, PIPE_DELAY=0 -> pix_tick constantly high; hsync_n equals the raw decode in the same cycle; line_start high every 800 clocks.
- Corner at (639,479) -> active=1; the next tick at (640,479) gives active=0, and the raw blank goes low there while blank_n goes low PIPE_DELAY ticks later; wrap (799,524)->(0,0) asserts frame_start.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants, screen window constants and sync bundle type.
package vga_pkg;

  // Default 640x480@60 raster timing (pixel ticks / lines).
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  // Image window used by the downstream coordinate/zoom mapper.
  localparam int IMG_W         = 320;
  localparam int IMG_H         = 240;
  localparam int IMG_X_OFF     = 160;
  localparam int IMG_Y_OFF     = 120;
  localparam int IMG_ADDR_W    = 17;
  localparam logic [IMG_ADDR_W-1:0] FALLBACK_ADDR = '0;

  // Sync/blank bundle carried through the alignment delay line.
  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic blank_n;
  } sync_t;

  // Idle value: syncs deasserted, video blanked.
  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0};

  // True when coordinate c lies in [lo, lo+len).
  function automatic logic in_win(input logic [9:0] c, input int lo, input int len);
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-gated shift register used to keep pixel-aligned signals in step
// with downstream pipeline latency. DEPTH=0 is a straight wire.
module sync_delay_line #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_wire
    logic unused_ctl;
    assign unused_ctl = &{1'b0, clock, reset, en};
    assign q = d;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stage;

    // Shift one stage per enable; reset loads every stage with the idle value.
    always_ff @(posedge clock) begin
      if (reset) begin
        stage <= {DEPTH{RST_VAL}};
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v scan counters, sync/blank decode
// and a delay line aligning sync/blank with the mapper + memory latency.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic       active,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       blank_n,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1 || CLK_DIV > 16 ||
      PIPE_DELAY < 0 || PIPE_DELAY > 8) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  logic [3:0] div_cnt;
  logic [9:0] h_cnt, v_cnt;
  logic       h_wrap;
  sync_t      raw, dly;

  assign pix_tick = (div_cnt == DIV_LAST);
  assign h_wrap   = (h_cnt == H_LAST);

  // Pixel-rate divider; with CLK_DIV=1 it stays at 0 and ticks every clock.
  always_ff @(posedge clock) begin
    if (reset)         div_cnt <= '0;
    else if (pix_tick) div_cnt <= '0;
    else               div_cnt <= div_cnt + 4'd1;
  end

  // Scan counters: h advances per tick, v advances on the h wrap tick.
  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      h_cnt <= h_wrap ? 10'd0 : h_cnt + 10'd1;
      if (h_wrap) v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
  end

  assign x_out  = h_cnt;
  assign y_out  = v_cnt;
  assign active = (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));

  // Undelayed sync/blank decode straight from the counters.
  always_comb begin
    raw         = SYNC_IDLE;
    raw.hsync_n = ~in_win(h_cnt, H_ACTIVE + H_FP, H_SYNC);
    raw.vsync_n = ~in_win(v_cnt, V_ACTIVE + V_FP, V_SYNC);
    raw.blank_n = active;
  end

  sync_delay_line #(
    .WIDTH  ($bits(sync_t)),
    .DEPTH  (PIPE_DELAY),
    .RST_VAL(SYNC_IDLE)
  ) u_dly (
    .clock(clock),
    .reset(reset),
    .en   (pix_tick),
    .d    (raw),
    .q    (dly)
  );

  assign hsync_n = dly.hsync_n;
  assign vsync_n = dly.vsync_n;
  assign blank_n = dly.blank_n;

  // Start strobes are not delayed: they mark the coordinates fed to the mapper.
  assign line_start  = pix_tick && (h_cnt == 10'd0);
  assign frame_start = line_start && (v_cnt == 10'd0);

endmodule
